pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: freezes on instruction or data memory wait, inserts load-use bubbles, flushes on redirect.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    input  logic        load_use,
    input  logic        branch_taken,
    output logic        pc_load,
    output logic        if_id_load,
    output logic        id_ex_load,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        mem_wb_clear,
    output logic        dmem_read_o,
    output logic        dmem_write_o,
    output logic [15:0] mem_rdata_o,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {RUN, DWAIT, DDONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        access, in_ddone, dstall, advance;

    assign access   = dmem_read | dmem_write;
    assign in_ddone = (state_q == DDONE);
    assign dstall   = access & ~dmem_resp & ~in_ddone;
    assign advance  = ~dstall & imem_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // DDONE remembers a finished data access while fetch is still stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (access && !dmem_resp)
                    state_d = DWAIT;
                else if (access && dmem_resp && !imem_resp)
                    state_d = DDONE;
            end
            DWAIT: begin
                if (dmem_resp && imem_resp)
                    state_d = RUN;
                else if (dmem_resp && !imem_resp)
                    state_d = DDONE;
            end
            DDONE: begin
                if (imem_resp)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (dmem_resp && !in_ddone)
            hold_d = dmem_rdata;
    end

    always_comb begin
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_clear = 1'b0;
        dmem_read_o  = dmem_read & ~in_ddone & ~reset;
        dmem_write_o = dmem_write & ~in_ddone & ~reset;
        mem_rdata_o  = in_ddone ? hold_q : dmem_rdata;
        if (reset) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
        end else if (advance) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (branch_taken) begin
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                ex_mem_clear = 1'b1;
            end else if (load_use) begin
                pc_load     = 1'b0;
                if_id_load  = 1'b0;
                id_ex_clear = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic        stall_evt;

    always_comb begin
        stall_evt     = ~advance | (load_use & ~branch_taken);
        stall_count_d = stall_count_q;
        if (stall_evt && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_count_q <= 16'd0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: vector table for single-cycle behaviour plus hand sequences for wait, done, reset and saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset, imem_resp, dmem_read, dmem_write, dmem_resp, load_use, branch_taken;
    logic [15:0] dmem_rdata;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
    logic        dmem_read_o, dmem_write_o;
    logic [15:0] mem_rdata_o, stall_count;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] sc_model;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .load_use(load_use), .branch_taken(branch_taken),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
        .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
        .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .mem_rdata_o(mem_rdata_o), .stall_count(stall_count)
    );

    typedef struct packed {
        logic        imem;
        logic        rd;
        logic        wr;
        logic        resp;
        logic [15:0] rdata;
        logic        lu;
        logic        br;
        logic [4:0]  e_load;
        logic [3:0]  e_clr;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_rdata;
        logic        e_stall;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_sc();
`ifdef PIPE_CTRL_PERF_EN
        return sc_model;
`else
        return 16'd0;
`endif
    endfunction

    task automatic drive(input logic imem, input logic rd, input logic wr, input logic resp,
                         input logic [15:0] rdata, input logic lu, input logic br);
        imem_resp    = imem;
        dmem_read    = rd;
        dmem_write   = wr;
        dmem_resp    = resp;
        dmem_rdata   = rdata;
        load_use     = lu;
        branch_taken = br;
        #1;
    endtask

    task automatic tick(input logic ev);
        @(posedge clk);
        if (reset)
            sc_model = 16'd0;
        else if (ev && sc_model != 16'hFFFF)
            sc_model = sc_model + 16'd1;
        #1;
    endtask

    task automatic check_out(input string name, input logic [4:0] e_load, input logic [3:0] e_clr,
                             input logic e_rd, input logic e_wr, input logic [15:0] e_rdata);
        chk({name, ".loads"}, {27'd0, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}, {27'd0, e_load});
        chk({name, ".clears"}, {28'd0, if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear}, {28'd0, e_clr});
        chk({name, ".strobes"}, {30'd0, dmem_read_o, dmem_write_o}, {30'd0, e_rd, e_wr});
        chk({name, ".rdata"}, {16'd0, mem_rdata_o}, {16'd0, e_rdata});
    endtask

    initial begin
        //              imem rd wr resp rdata     lu br  loads     clears   rd wr e_rdata   stall
        vecs[0] = '{1'b1,1'b0,1'b0,1'b0,16'h00A5,1'b0,1'b0,5'b11111,4'b0000,1'b0,1'b0,16'h00A5,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b0,1'b0,16'h0011,1'b0,1'b0,5'b00000,4'b0000,1'b0,1'b0,16'h0011,1'b1};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,16'h0022,1'b1,1'b0,5'b00111,4'b0100,1'b0,1'b0,16'h0022,1'b1};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b0,16'h0033,1'b1,1'b1,5'b11111,4'b1110,1'b0,1'b0,16'h0033,1'b0};
        vecs[4] = '{1'b1,1'b0,1'b0,1'b0,16'h0044,1'b0,1'b1,5'b11111,4'b1110,1'b0,1'b0,16'h0044,1'b0};
        vecs[5] = '{1'b0,1'b0,1'b0,1'b0,16'h0055,1'b0,1'b1,5'b00000,4'b0000,1'b0,1'b0,16'h0055,1'b1};
        vecs[6] = '{1'b0,1'b0,1'b0,1'b0,16'h0066,1'b1,1'b0,5'b00000,4'b0000,1'b0,1'b0,16'h0066,1'b1};
        vecs[7] = '{1'b1,1'b1,1'b0,1'b1,16'hBEEF,1'b0,1'b0,5'b11111,4'b0000,1'b1,1'b0,16'hBEEF,1'b0};
        vecs[8] = '{1'b1,1'b0,1'b1,1'b1,16'hCAFE,1'b0,1'b0,5'b11111,4'b0000,1'b0,1'b1,16'hCAFE,1'b0};
        vecs[9] = '{1'b1,1'b1,1'b0,1'b1,16'h0F0F,1'b1,1'b0,5'b00111,4'b0100,1'b1,1'b0,16'h0F0F,1'b1};

        sc_model = 16'd0;
        reset    = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(1'b0);
        check_out("reset", 5'b00000, 4'b1111, 1'b0, 1'b0, 16'h0000);
        chk("reset.sc", {16'd0, stall_count}, {16'd0, exp_sc()});
        tick(1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].imem, vecs[i].rd, vecs[i].wr, vecs[i].resp, vecs[i].rdata, vecs[i].lu, vecs[i].br);
            check_out($sformatf("vec%0d", i), vecs[i].e_load, vecs[i].e_clr, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_rdata);
            chk($sformatf("vec%0d.sc", i), {16'd0, stall_count}, {16'd0, exp_sc()});
            tick(vecs[i].e_stall);
        end

        // Data wait: three stalled cycles then response
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            check_out($sformatf("dwait%0d", i), 5'b00000, 4'b0000, 1'b1, 1'b0, 16'h0000);
            tick(1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
        check_out("dwait.resp", 5'b11111, 4'b0000, 1'b1, 1'b0, 16'h4321);
        chk("dwait.sc", {16'd0, stall_count}, {16'd0, exp_sc()});
        tick(1'b0);

        // Data done while fetch stalls: held data survives rdata changes
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        check_out("ddone.enter", 5'b00000, 4'b0000, 1'b1, 1'b0, 16'h1234);
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        check_out("ddone.hold", 5'b00000, 4'b0000, 1'b0, 1'b0, 16'h1234);
        tick(1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        check_out("ddone.adv", 5'b11111, 4'b0000, 1'b0, 1'b0, 16'h1234);
        tick(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        check_out("ddone.exit", 5'b11111, 4'b0000, 1'b0, 1'b0, 16'hFFFF);
        chk("ddone.sc", {16'd0, stall_count}, {16'd0, exp_sc()});
        tick(1'b0);

        // Reset in the middle of a data wait
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(1'b1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_out("rst_dwait", 5'b00000, 4'b1111, 1'b0, 1'b0, 16'h0000);
        tick(1'b0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_out("rst_dwait.post", 5'b11111, 4'b0000, 1'b0, 1'b0, 16'h0000);
        chk("rst_dwait.sc", {16'd0, stall_count}, 32'd0);
        tick(1'b0);

        // Reset while in DDONE: first cycle after must be RUN (strobe passes)
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        tick(1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        check_out("rst_ddone", 5'b00000, 4'b1111, 1'b0, 1'b0, 16'h5555);
        tick(1'b0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
        check_out("rst_ddone.post", 5'b11111, 4'b0000, 1'b1, 1'b0, 16'h7777);
        tick(1'b0);

        // Long freeze to drive the counter into saturation
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_out("freeze", 5'b00000, 4'b0000, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 65540; i++)
            tick(1'b1);
        chk("sat.sc", {16'd0, stall_count}, {16'd0, exp_sc()});
        tick(1'b1);
        tick(1'b1);
        chk("sat.hold", {16'd0, stall_count}, {16'd0, exp_sc()});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
